// File: rtl/addsub_pkg.sv
// Shared types and default widths for the adder/subtractor operand sequencer.
package addsub_pkg;

    // Sequencer phases: collect A, collect B, latch adder output, offer result.
    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } seq_state_t;

    localparam int NBIT_DEFAULT = 10;
    localparam int CNTW_DEFAULT = 8;

endpackage

// File: rtl/addsub_operand_sequencer.sv
// Operand sequencer for the N-bit adder/subtractor: collects A and B from a
// single valid/ready operand stream, holds them (with the op select) stable
// for a sibling adder, registers the adder's result onto a valid/ready output
// and counts completed result handshakes.
module addsub_operand_sequencer
    import addsub_pkg::*;
#(
    parameter int NBIT = NBIT_DEFAULT,
    parameter int CNTW = CNTW_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NBIT-1:0] data_i,
    input  logic            data_valid_i,
    output logic            data_ready_o,
    input  logic            sub_i,
    output logic [NBIT-1:0] firstByte_o,
    output logic [NBIT-1:0] secondByte_o,
    output logic            sub_o,
    input  logic [NBIT:0]   result_i,
    output logic [NBIT:0]   result_o,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic            busy_o,
    output logic [CNTW-1:0] op_count_o
);

    seq_state_t state;
    seq_state_t state_nxt;
    logic       beat_hs;
    logic       res_hs;

    assign beat_hs = data_valid_i & data_ready_o;
    assign res_hs  = result_valid_o & result_ready_i;

    // Next-state, input-ready and busy decode from the current phase.
    // Ready is forced low during reset so no beat is ever taken then.
    always_comb begin
        state_nxt    = state;
        data_ready_o = 1'b0;
        busy_o       = 1'b1;
        unique case (state)
            LOAD_A: begin
                data_ready_o = ~rst_i;
                busy_o       = 1'b0;
                if (data_valid_i && !rst_i) state_nxt = LOAD_B;
            end
            LOAD_B: begin
                data_ready_o = ~rst_i;
                if (data_valid_i && !rst_i) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (result_valid_o && result_ready_i) state_nxt = LOAD_A;
            end
            default: begin
                state_nxt = LOAD_A;
            end
        endcase
    end

    // Phase register, operand/op-select latches, result register and counter.
    // Operands persist after CAPTURE so the adder inputs stay stable in HOLD.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= LOAD_A;
            firstByte_o    <= '0;
            secondByte_o   <= '0;
            sub_o          <= 1'b0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            op_count_o     <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                LOAD_A: begin
                    if (beat_hs) begin
                        firstByte_o <= data_i;
                        sub_o       <= sub_i;
                    end
                end
                LOAD_B: begin
                    if (beat_hs) secondByte_o <= data_i;
                end
                CAPTURE: begin
                    result_o       <= result_i;
                    result_valid_o <= 1'b1;
                end
                HOLD: begin
                    if (res_hs) begin
                        result_valid_o <= 1'b0;
                        op_count_o     <= op_count_o + CNTW'(1);
                    end
                end
                default: begin
                    result_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_operand_sequencer.sv
// Self-checking bench for addsub_operand_sequencer with behavioural adders.
module tb_addsub_operand_sequencer;

    localparam int NB = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] data = '0;
    logic          dvalid = 1'b0;
    logic          sub = 1'b0;
    logic          rready = 1'b0;

    logic          ready, so, rvalid, busy;
    logic [NB-1:0] fa, fb;
    logic [NB:0]   res_in, res_o;
    logic [7:0]    cnt;

    logic          ready2, so2, rvalid2, busy2;
    logic [NB-1:0] fa2, fb2;
    logic [NB:0]   res_in2, res_o2;
    logic [1:0]    cnt2;

    always #5 clk = ~clk;

    // Sibling adders: A+B or A-B modulo 2^(NB+1)
    assign res_in  = so  ? ({1'b0, fa}  - {1'b0, fb})  : ({1'b0, fa}  + {1'b0, fb});
    assign res_in2 = so2 ? ({1'b0, fa2} - {1'b0, fb2}) : ({1'b0, fa2} + {1'b0, fb2});

    addsub_operand_sequencer #(.NBIT(NB), .CNTW(8)) dut (
        .clk_i(clk), .rst_i(rst), .data_i(data), .data_valid_i(dvalid),
        .data_ready_o(ready), .sub_i(sub), .firstByte_o(fa), .secondByte_o(fb),
        .sub_o(so), .result_i(res_in), .result_o(res_o), .result_valid_o(rvalid),
        .result_ready_i(rready), .busy_o(busy), .op_count_o(cnt)
    );

    addsub_operand_sequencer #(.NBIT(NB), .CNTW(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .data_valid_i(dvalid),
        .data_ready_o(ready2), .sub_i(sub), .firstByte_o(fa2), .secondByte_o(fb2),
        .sub_o(so2), .result_i(res_in2), .result_o(res_o2), .result_valid_o(rvalid2),
        .result_ready_i(rready), .busy_o(busy2), .op_count_o(cnt2)
    );

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [NB-1:0] a;
        logic [NB-1:0] b;
        logic          sa;
        logic          sb;
        logic [NB:0]   exp;
    } vec_t;

    vec_t tbl[6];

    int beats[$];
    bit subs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NB:0] model(input int a, input int b, input bit s);
        int r;
        r = s ? (a - b) : (a + b);
        return NB'(0) + (r & ((1 << (NB + 1)) - 1));
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        dvalid = 1'b1;
        data = 10'd77;
        rready = 1'b0;
        #1;
        chk("rst_ready_low", ready, 0);
        step();
        step();
        chk("rst_fa", fa, 0);
        chk("rst_fb", fb, 0);
        chk("rst_so", so, 0);
        chk("rst_res", res_o, 0);
        chk("rst_valid", rvalid, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_ready", ready, 0);
        rst = 1'b0;
        dvalid = 1'b0;
        exp_cnt = 0;
        #1;
        chk("post_rst_ready", ready, 1);
        chk("post_rst_busy", busy, 0);
    endtask

    // One operation with exact cycle-by-cycle expectations, ready held high.
    task automatic run_op(input logic [NB-1:0] a, input logic [NB-1:0] b,
                          input logic sa, input logic sb, input logic [NB:0] exp);
        dvalid = 1'b1; data = a; sub = sa; rready = 1'b1;
        #1;
        chk("opA_ready", ready, 1);
        chk("opA_busy", busy, 0);
        step();
        chk("opB_fa", fa, a);
        chk("opB_so", so, sa);
        chk("opB_busy", busy, 1);
        data = b; sub = sb;
        #1;
        chk("opB_ready", ready, 1);
        step();
        dvalid = 1'b0;
        chk("cap_fb", fb, b);
        chk("cap_ready", ready, 0);
        chk("cap_valid_t1", rvalid, 0);
        step();
        chk("hold_valid_t2", rvalid, 1);
        chk("hold_res", res_o, exp);
        chk("hold_cnt", cnt, exp_cnt % 256);
        chk("hold_so_stable", so, sa);
        step();
        exp_cnt++;
        chk("done_valid", rvalid, 0);
        chk("done_busy", busy, 0);
        chk("done_cnt", cnt, exp_cnt % 256);
        chk("done_cnt2", cnt2, exp_cnt % 4);
    endtask

    // Streams beats from the queues; pairing and arithmetic done by the bench.
    task automatic stream(input int nops, input bit rnd);
        int done_ops = 0;
        int cyc = 0;
        int last_hs = -1;
        bit have_a = 0;
        int a_v = 0;
        bit s_v = 0;
        logic [NB:0] expq[$];
        logic [NB:0] prev_res = '0;
        bit prev_pend = 0;
        while (done_ops < nops && cyc < 3000) begin
            dvalid = (beats.size() > 0) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            data = (beats.size() > 0) ? NB'(beats[0]) : '0;
            sub = (subs.size() > 0) ? subs[0] : 1'b0;
            rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (rvalid && prev_pend) chk("hold_stable", res_o, prev_res);
            if (rvalid && rready) begin
                if (expq.size() == 0) chk("unexpected_result", res_o, 32'hFFFF_FFFF);
                else chk("stream_res", res_o, expq.pop_front());
                chk("stream_cnt", cnt, exp_cnt % 256);
                chk("stream_cnt2", cnt2, exp_cnt % 4);
                if (!rnd && last_hs >= 0) chk("spacing", cyc - last_hs, 4);
                last_hs = cyc;
                exp_cnt++;
                done_ops++;
                prev_pend = 0;
            end else begin
                prev_pend = rvalid;
                prev_res = res_o;
            end
            if (dvalid && ready) begin
                if (!have_a) begin
                    a_v = beats[0];
                    s_v = subs[0];
                    have_a = 1;
                end else begin
                    expq.push_back(model(a_v, beats[0], s_v));
                    have_a = 0;
                end
                void'(beats.pop_front());
                void'(subs.pop_front());
            end
            step();
            cyc++;
        end
        chk("stream_ops_done", done_ops, nops);
        dvalid = 1'b0;
        #1;
        chk("stream_final_cnt", cnt, exp_cnt % 256);
    endtask

    initial begin
        tbl[0] = '{a: 10'd1023, b: 10'd1,    sa: 1'b0, sb: 1'b0, exp: 11'h400};
        tbl[1] = '{a: 10'd5,    b: 10'd7,    sa: 1'b1, sb: 1'b0, exp: 11'h7FE};
        tbl[2] = '{a: 10'd0,    b: 10'd0,    sa: 1'b0, sb: 1'b1, exp: 11'h000};
        tbl[3] = '{a: 10'd0,    b: 10'd1,    sa: 1'b1, sb: 1'b1, exp: 11'h7FF};
        tbl[4] = '{a: 10'd1023, b: 10'd1023, sa: 1'b0, sb: 1'b1, exp: 11'h7FE};
        tbl[5] = '{a: 10'd512,  b: 10'd512,  sa: 1'b1, sb: 1'b0, exp: 11'h000};

        step();
        do_reset();

        for (int i = 0; i < 6; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].sa, tbl[i].sb, tbl[i].exp);

        // Backpressure: result held for 10 cycles, offered beat not taken
        dvalid = 1'b1; data = 10'd100; sub = 1'b0; rready = 1'b0;
        step();
        data = 10'd27;
        step();
        data = 10'd999;
        step();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", rvalid, 1);
            chk("bp_res", res_o, 127);
            chk("bp_ready", ready, 0);
            chk("bp_cnt", cnt, exp_cnt % 256);
        end
        chk("bp_fa_kept", fa, 100);
        chk("bp_fb_kept", fb, 27);
        dvalid = 1'b0; rready = 1'b1;
        step();
        exp_cnt++;
        chk("bp_release_cnt", cnt, exp_cnt % 256);
        chk("bp_release_busy", busy, 0);
        chk("bp_release_valid", rvalid, 0);

        // Reset in LOAD_B
        dvalid = 1'b1; data = 10'd11; sub = 1'b1;
        step();
        data = 10'd22;
        rst = 1'b1;
        #1;
        chk("rstB_ready", ready, 0);
        step();
        rst = 1'b0; dvalid = 1'b0;
        exp_cnt = 0;
        chk("rstB_busy", busy, 0);
        chk("rstB_fa", fa, 0);
        chk("rstB_so", so, 0);
        chk("rstB_cnt", cnt, 0);
        run_op(10'd300, 10'd45, 1'b0, 1'b1, 11'd345);

        // Reset in HOLD with an unaccepted result
        dvalid = 1'b1; data = 10'd40; sub = 1'b1; rready = 1'b0;
        step();
        data = 10'd2;
        step();
        dvalid = 1'b0;
        step();
        chk("rstH_valid_pre", rvalid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = 0;
        chk("rstH_valid", rvalid, 0);
        chk("rstH_res", res_o, 0);
        chk("rstH_cnt", cnt, 0);
        chk("rstH_fb", fb, 0);
        chk("rstH_busy", busy, 0);
        run_op(10'd40, 10'd2, 1'b1, 1'b0, 11'd38);

        // Back-to-back stream with valid held high: 3,4,9,2 then random
        do_reset();
        beats = {3, 4, 9, 2};
        subs = {1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            beats.push_back($urandom_range(0, 1023));
            subs.push_back(1'($urandom_range(0, 1)));
        end
        stream(5, 1'b0);
        chk("wrap_cnt2", cnt2, 1);

        // Randomized valid/ready traffic
        beats.delete();
        subs.delete();
        for (int i = 0; i < 80; i++) begin
            beats.push_back($urandom_range(0, 1023));
            subs.push_back(1'($urandom_range(0, 1)));
        end
        stream(40, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
